// File: rtl/fifo_checker.sv
// Purpose : cycle-accurate scoreboard for the synchronous FIFO; shadows the FIFO and compares every output each cycle.
// Latency : one cycle from a DUT output to o_err_mask and the counters.
// Backpr. : none; purely passive, never stalls the DUT or the stimulus.
//
// Ports:
//   i_clk, i_rst              clock and async active-high reset shared with the DUT
//   i_check_en                compare enable (the model keeps tracking when low)
//   i_wr_en, i_rd_en, i_data_in   DUT inputs, tapped
//   i_data_out, i_wr_ack, i_overflow, i_underflow,
//   i_full, i_almostfull, i_empty, i_almostempty   DUT outputs under check
//   o_err_mask                registered mismatch vector of the last compare
//                             [0] data_out [1] wr_ack [2] overflow [3] underflow
//                             [4] full [5] almostfull [6] empty [7] almostempty
//   o_correct_count, o_error_count   saturating compare counters
//   o_first_err_valid/_mask/_cycle   sticky record of the first mismatch
module fifo_checker #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_check_en,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic [FIFO_WIDTH-1:0] i_data_in,
  input  logic [FIFO_WIDTH-1:0] i_data_out,
  input  logic                  i_wr_ack,
  input  logic                  i_overflow,
  input  logic                  i_underflow,
  input  logic                  i_full,
  input  logic                  i_almostfull,
  input  logic                  i_empty,
  input  logic                  i_almostempty,
  output logic [7:0]            o_err_mask,
  output logic [CNT_W-1:0]      o_correct_count,
  output logic [CNT_W-1:0]      o_error_count,
  output logic                  o_first_err_valid,
  output logic [7:0]            o_first_err_mask,
  output logic [CNT_W-1:0]      o_first_err_cycle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_AFUL = OCC_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Shadow FIFO state
  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_count;
  logic [FIFO_WIDTH-1:0] r_m_data_out;
  logic                  r_m_wr_ack;
  logic                  r_m_overflow;
  logic                  r_m_underflow;

  // Scoreboard state
  logic [CNT_W-1:0]      r_cycle_count;
  logic [7:0]            r_err_mask;
  logic [CNT_W-1:0]      r_correct_count;
  logic [CNT_W-1:0]      r_error_count;
  logic                  r_first_err_valid;
  logic [7:0]            r_first_err_mask;
  logic [CNT_W-1:0]      r_first_err_cycle;

  logic                  w_do_wr;
  logic                  w_do_rd;
  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;
  logic                  w_m_full;
  logic                  w_m_almostfull;
  logic                  w_m_empty;
  logic                  w_m_almostempty;
  logic [7:0]            w_mismatch;

  assign w_do_wr = i_wr_en && (r_count != OCC_FULL);
  assign w_do_rd = i_rd_en && (r_count != '0);

  // Depth need not be a power of two, so wrap by compare rather than overflow.
  assign w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

  assign w_m_full        = (r_count == OCC_FULL);
  assign w_m_almostfull  = (r_count == OCC_AFUL);
  assign w_m_empty       = (r_count == '0);
  assign w_m_almostempty = (r_count == OCC_ONE);

  // The model registers were updated on the same edge as the DUT, so the
  // DUT outputs visible now line up with the model state visible now.
  assign w_mismatch = {
    i_almostempty ^ w_m_almostempty,
    i_empty       ^ w_m_empty,
    i_almostfull  ^ w_m_almostfull,
    i_full        ^ w_m_full,
    i_underflow   ^ r_m_underflow,
    i_overflow    ^ r_m_overflow,
    i_wr_ack      ^ r_m_wr_ack,
    |(i_data_out  ^ r_m_data_out)
  };

  // Entry storage carries no reset; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_data_in;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_m_data_out  <= '0;
      r_m_wr_ack    <= 1'b0;
      r_m_overflow  <= 1'b0;
      r_m_underflow <= 1'b0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_do_rd) begin
        r_rd_ptr     <= w_rd_ptr_nxt;
        r_m_data_out <= r_mem[r_rd_ptr];
      end
      r_m_wr_ack    <= w_do_wr;
      r_m_overflow  <= i_wr_en && !w_do_wr;
      r_m_underflow <= i_rd_en && !w_do_rd;
      r_count       <= r_count + OCC_W'(w_do_wr) - OCC_W'(w_do_rd);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cycle_count     <= '0;
      r_err_mask        <= '0;
      r_correct_count   <= '0;
      r_error_count     <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_mask  <= '0;
      r_first_err_cycle <= '0;
    end else begin
      if (r_cycle_count != CNT_MAX) begin
        r_cycle_count <= r_cycle_count + 1'b1;
      end
      if (i_check_en) begin
        r_err_mask <= w_mismatch;
        if (w_mismatch == '0) begin
          if (r_correct_count != CNT_MAX) begin
            r_correct_count <= r_correct_count + 1'b1;
          end
        end else begin
          if (r_error_count != CNT_MAX) begin
            r_error_count <= r_error_count + 1'b1;
          end
          // Records the pre-increment cycle value of the failing compare edge.
          if (!r_first_err_valid) begin
            r_first_err_valid <= 1'b1;
            r_first_err_mask  <= w_mismatch;
            r_first_err_cycle <= r_cycle_count;
          end
        end
      end else begin
        r_err_mask <= '0;
      end
    end
  end

  assign o_err_mask        = r_err_mask;
  assign o_correct_count   = r_correct_count;
  assign o_error_count     = r_error_count;
  assign o_first_err_valid = r_first_err_valid;
  assign o_first_err_mask  = r_first_err_mask;
  assign o_first_err_cycle = r_first_err_cycle;

endmodule

// File: tb/tb_fifo_checker.sv
// Purpose : exercises two fifo_checker instances (depth 8 / 32-bit counters, depth 5 / 4-bit counters)
//           with a queue-based FIFO standing in for the checked DUT, plus deliberate output corruption.
// Latency : expectations advance on each posedge and are compared at the following negedge.
// Backpr. : none.
module tb_fifo_checker;

  localparam int W  = 16;
  localparam int DA = 8;
  localparam int DB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         check_en;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] din;

  logic [W-1:0] a_dout, b_dout;
  logic a_ack, a_ovf, a_udf, a_full, a_af, a_emp, a_ae;
  logic b_ack, b_ovf, b_udf, b_full, b_af, b_emp, b_ae;

  logic [7:0]  a_mask, b_mask, a_fm, b_fm;
  logic [31:0] a_corr, a_errc, a_fc;
  logic [3:0]  b_corr, b_errc, b_fc;
  logic        a_fv, b_fv;

  fifo_checker #(.FIFO_WIDTH(W), .FIFO_DEPTH(DA), .CNT_W(32)) u_chk_a (
    .i_clk(clk), .i_rst(rst), .i_check_en(check_en),
    .i_wr_en(wr_en), .i_rd_en(rd_en), .i_data_in(din),
    .i_data_out(a_dout), .i_wr_ack(a_ack), .i_overflow(a_ovf), .i_underflow(a_udf),
    .i_full(a_full), .i_almostfull(a_af), .i_empty(a_emp), .i_almostempty(a_ae),
    .o_err_mask(a_mask), .o_correct_count(a_corr), .o_error_count(a_errc),
    .o_first_err_valid(a_fv), .o_first_err_mask(a_fm), .o_first_err_cycle(a_fc)
  );

  fifo_checker #(.FIFO_WIDTH(W), .FIFO_DEPTH(DB), .CNT_W(4)) u_chk_b (
    .i_clk(clk), .i_rst(rst), .i_check_en(check_en),
    .i_wr_en(wr_en), .i_rd_en(rd_en), .i_data_in(din),
    .i_data_out(b_dout), .i_wr_ack(b_ack), .i_overflow(b_ovf), .i_underflow(b_udf),
    .i_full(b_full), .i_almostfull(b_af), .i_empty(b_emp), .i_almostempty(b_ae),
    .o_err_mask(b_mask), .o_correct_count(b_corr), .o_error_count(b_errc),
    .o_first_err_valid(b_fv), .o_first_err_mask(b_fm), .o_first_err_cycle(b_fc)
  );

  // Reference FIFOs (index 0 = depth 8, index 1 = depth 5)
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] m_dout [2];
  logic         m_ack  [2];
  logic         m_ovf  [2];
  logic         m_udf  [2];

  // Expected checker outputs
  logic [7:0] e_mask [2];
  logic [7:0] e_fm   [2];
  logic       e_fv   [2];
  longint     e_corr [2];
  longint     e_errc [2];
  longint     e_fc   [2];
  longint     e_cyc  [2];
  longint     cmax   [2];

  int n_checks;
  int n_errors;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fsize(input int k);
    return (k == 0) ? qa.size() : qb.size();
  endfunction

  // Present the reference FIFO outputs to the checkers, corrupting the bits
  // selected by fa/fb. A data fault forces 16'hDEAD onto data_out.
  task automatic drive(input logic [7:0] fa, input logic [7:0] fb);
    int sa;
    int sb;
    sa = qa.size();
    sb = qb.size();
    a_dout = fa[0] ? 16'hDEAD : m_dout[0];
    a_ack  = m_ack[0] ^ fa[1];
    a_ovf  = m_ovf[0] ^ fa[2];
    a_udf  = m_udf[0] ^ fa[3];
    a_full = (sa == DA)     ^ fa[4];
    a_af   = (sa == DA - 1) ^ fa[5];
    a_emp  = (sa == 0)      ^ fa[6];
    a_ae   = (sa == 1)      ^ fa[7];
    b_dout = fb[0] ? 16'hDEAD : m_dout[1];
    b_ack  = m_ack[1] ^ fb[1];
    b_ovf  = m_ovf[1] ^ fb[2];
    b_udf  = m_udf[1] ^ fb[3];
    b_full = (sb == DB)     ^ fb[4];
    b_af   = (sb == DB - 1) ^ fb[5];
    b_emp  = (sb == 0)      ^ fb[6];
    b_ae   = (sb == 1)      ^ fb[7];
  endtask

  task automatic fifo_upd(input int k, input logic w, input logic r, input logic [W-1:0] d);
    int   depth;
    int   sz;
    logic dw;
    logic dr;
    depth = (k == 0) ? DA : DB;
    sz    = fsize(k);
    dw    = w && (sz != depth);
    dr    = r && (sz != 0);
    if (dr) begin
      if (k == 0) m_dout[k] = qa.pop_front();
      else        m_dout[k] = qb.pop_front();
    end
    if (dw) begin
      if (k == 0) qa.push_back(d);
      else        qb.push_back(d);
    end
    m_ack[k] = dw;
    m_ovf[k] = w && !dw;
    m_udf[k] = r && !dr;
  endtask

  task automatic exp_upd(input int k, input logic ce, input logic [7:0] mm);
    if (ce) begin
      e_mask[k] = mm;
      if (mm == 8'h00) begin
        if (e_corr[k] < cmax[k]) e_corr[k]++;
      end else begin
        if (e_errc[k] < cmax[k]) e_errc[k]++;
        if (!e_fv[k]) begin
          e_fv[k] = 1'b1;
          e_fm[k] = mm;
          e_fc[k] = e_cyc[k];
        end
      end
    end else begin
      e_mask[k] = 8'h00;
    end
    if (e_cyc[k] < cmax[k]) e_cyc[k]++;
  endtask

  task automatic compare_all();
    chk("a_err_mask",  longint'(a_mask), longint'(e_mask[0]));
    chk("a_correct",   longint'(a_corr), e_corr[0]);
    chk("a_errors",    longint'(a_errc), e_errc[0]);
    chk("a_first_vld", longint'(a_fv),   longint'(e_fv[0]));
    chk("a_first_msk", longint'(a_fm),   longint'(e_fm[0]));
    chk("a_first_cyc", longint'(a_fc),   e_fc[0]);
    chk("b_err_mask",  longint'(b_mask), longint'(e_mask[1]));
    chk("b_correct",   longint'(b_corr), e_corr[1]);
    chk("b_errors",    longint'(b_errc), e_errc[1]);
    chk("b_first_vld", longint'(b_fv),   longint'(e_fv[1]));
    chk("b_first_msk", longint'(b_fm),   longint'(e_fm[1]));
    chk("b_first_cyc", longint'(b_fc),   e_fc[1]);
  endtask

  // One clock: drive at negedge, advance models at posedge, compare at next negedge.
  task automatic step(input logic w, input logic r, input logic [W-1:0] d, input logic ce,
                      input logic [7:0] fa, input logic [7:0] fb);
    logic [7:0] ma;
    logic [7:0] mb;
    wr_en    = w;
    rd_en    = r;
    din      = d;
    check_en = ce;
    drive(fa, fb);
    ma    = fa;
    ma[0] = fa[0] && (m_dout[0] != 16'hDEAD);
    mb    = fb;
    mb[0] = fb[0] && (m_dout[1] != 16'hDEAD);
    @(posedge clk);
    exp_upd(0, ce, ma);
    exp_upd(1, ce, mb);
    fifo_upd(0, w, r, d);
    fifo_upd(1, w, r, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    check_en = 1'b0;
    din      = '0;
    qa.delete();
    qb.delete();
    for (int k = 0; k < 2; k++) begin
      m_dout[k] = '0;
      m_ack[k]  = 1'b0;
      m_ovf[k]  = 1'b0;
      m_udf[k]  = 1'b0;
      e_mask[k] = 8'h00;
      e_fm[k]   = 8'h00;
      e_fv[k]   = 1'b0;
      e_corr[k] = 0;
      e_errc[k] = 0;
      e_fc[k]   = 0;
      e_cyc[k]  = 0;
    end
    drive(8'h00, 8'h00);
    repeat (n) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  task automatic rand_steps(input int n);
    logic [7:0] fa;
    logic [7:0] fb;
    for (int i = 0; i < n; i++) begin
      fa = 8'h00;
      fb = 8'h00;
      if ($urandom_range(0, 11) == 0) fa = 8'h01 << $urandom_range(0, 7);
      if ($urandom_range(0, 29) == 0) fb = 8'h01 << $urandom_range(0, 7);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
           ($urandom_range(0, 9) != 0), fa, fb);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cmax[0]  = 64'h0000_0000_FFFF_FFFF;
    cmax[1]  = 15;

    do_reset(3);

    // Idle after reset: five clean compares
    repeat (5) step(1'b0, 1'b0, '0, 1'b1, 8'h00, 8'h00);
    chk("idle_correct", longint'(a_corr), 5);
    chk("idle_errors",  longint'(a_errc), 0);
    chk("idle_mask",    longint'(a_mask), 0);

    // Fill 1..8 then overflow with 9
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, W'(i), 1'b1, 8'h00, 8'h00);
    chk("fill_errors", longint'(a_errc), 0);

    // Drain 8 plus one underflow; data_out forced to DEAD on the cycle-20 compare
    for (int i = 0; i < 9; i++)
      step(1'b0, 1'b1, '0, 1'b1, (e_cyc[0] == 20) ? 8'h01 : 8'h00, 8'h00);
    chk("first_valid", longint'(a_fv), 1);
    chk("first_mask",  longint'(a_fm), 8'h01);
    chk("first_cycle", longint'(a_fc), 20);
    chk("first_count", longint'(a_errc), 1);

    // Simultaneous read/write at full, then at empty
    for (int i = 0; i < DA; i++) step(1'b1, 1'b0, W'(16'h0100 + i), 1'b1, 8'h00, 8'h00);
    step(1'b1, 1'b1, 16'h0BAD, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b0, '0, 1'b1, 8'h00, 8'h00);
    for (int i = 0; i < DA; i++) step(1'b0, 1'b1, '0, 1'b1, 8'h00, 8'h00);
    step(1'b1, 1'b1, 16'h0A0A, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b0, '0, 1'b1, 8'h00, 8'h00);

    // A later fault leaves the first-error record alone
    step(1'b0, 1'b0, '0, 1'b1, 8'h10, 8'h00);
    chk("later_cycle", longint'(a_fc), 20);
    chk("later_mask",  longint'(a_fm), 8'h01);
    chk("later_count", longint'(a_errc), 2);

    // Narrow instance: cycle counter has saturated at 15
    step(1'b0, 1'b0, '0, 1'b1, 8'h00, 8'h40);
    chk("b_sat_cycle", longint'(b_fc), 15);
    chk("b_sat_mask",  longint'(b_fm), 8'h40);

    // Fault hidden while compares are disabled
    step(1'b1, 1'b0, 16'h1234, 1'b0, 8'hFF, 8'hFF);

    // Wrap-around write/read pairs
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, W'($urandom), 1'b1, 8'h00, 8'h00);
      step(1'b0, 1'b1, '0, 1'b1, 8'h00, 8'h00);
    end

    rand_steps(250);

    // Mid-stream reset
    do_reset(2);
    repeat (5) step(1'b0, 1'b0, '0, 1'b1, 8'h00, 8'h00);
    chk("rst_a_correct", longint'(a_corr), 5);
    chk("rst_b_correct", longint'(b_corr), 5);

    rand_steps(120);
    repeat (20) step(1'b0, 1'b0, '0, 1'b1, 8'h00, 8'h00);
    chk("b_correct_sat", longint'(b_corr), 15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
